// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one external combinational barrel shifter among
// NREQ requesters through a two-stage issue/result pipeline with valid/ready on both sides.
module shift_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [32*NREQ-1:0]  req_x,
   input  logic [5*NREQ-1:0]   req_s,
   input  logic [NREQ-1:0]     req_left,
   input  logic [NREQ-1:0]     req_log,
   output logic [31:0]         sh_x,
   output logic [4:0]          sh_s,
   output logic                sh_left,
   output logic                sh_log,
   input  logic [31:0]         sh_z,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_z,
   output logic [IDW-1:0]      rsp_id,
   output logic [1:0]          occ,
   output logic [CNTW-1:0]     opcnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      RES   = 2'b01,
      ISS   = 2'b10,
      FULL  = 2'b11
   } pipe_state_t;

   pipe_state_t     state_r;
   pipe_state_t     state_nx_s;
   logic            run_r;
   logic [IDW-1:0]  ptr_r;
   logic [IDW-1:0]  ptr_nx_s;
   logic [IDW-1:0]  gnt_id_s;
   logic            gnt_found_s;
   logic            take_s;
   int              best_d_s;
   int              dist_s;
   logic            iss_v_s;
   logic            res_v_s;
   logic            res_adv_s;
   logic            iss_free_s;
   logic            grant_s;
   logic [31:0]     sel_x_s;
   logic [4:0]      sel_s_s;
   logic            sel_left_s;
   logic            sel_log_s;
   logic [31:0]     iss_x_r;
   logic [4:0]      iss_s_r;
   logic            iss_left_r;
   logic            iss_log_r;
   logic [IDW-1:0]  iss_id_r;
   logic [31:0]     rsp_z_r;
   logic [IDW-1:0]  rsp_id_r;
   logic [1:0]      occ_r;
   logic [CNTW-1:0] opcnt_r;

   assign iss_v_s    = (state_r == ISS) || (state_r == FULL);
   assign res_v_s    = (state_r == RES) || (state_r == FULL);
   assign res_adv_s  = iss_v_s & (~res_v_s | rsp_ready);
   assign iss_free_s = ~iss_v_s | res_adv_s;
   // run_r keeps grants off while reset is asserted and for the first edge after release
   assign grant_s    = run_r & iss_free_s & gnt_found_s;
   assign ptr_nx_s   = (int'(gnt_id_s) == NREQ - 1) ? {IDW{1'b0}} : gnt_id_s + IDW'(1);

   // Rotating-priority search: the valid requester nearest at or above the pointer wins
   always_comb begin
      best_d_s = NREQ;
      dist_s   = 0;
      take_s   = 1'b0;
      gnt_id_s = {IDW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         dist_s   = (i >= int'(ptr_r)) ? (i - int'(ptr_r)) : (i + NREQ - int'(ptr_r));
         take_s   = req_valid[i] && (dist_s < best_d_s);
         gnt_id_s = take_s ? IDW'(i) : gnt_id_s;
         best_d_s = take_s ? dist_s : best_d_s;
      end
      gnt_found_s = (best_d_s < NREQ);
   end

   // Payload mux and one-hot ready for the granted requester
   always_comb begin
      sel_x_s    = 32'h0000_0000;
      sel_s_s    = 5'd0;
      sel_left_s = 1'b0;
      sel_log_s  = 1'b0;
      req_ready  = {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == gnt_id_s) begin
            sel_x_s      = req_x[32*i +: 32];
            sel_s_s      = req_s[5*i +: 5];
            sel_left_s   = req_left[i];
            sel_log_s    = req_log[i];
            req_ready[i] = grant_s;
         end else begin
            req_ready[i] = 1'b0;
         end
      end
   end

   // Next state of the issue/result pipeline
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         EMPTY: state_nx_s = grant_s ? ISS : EMPTY;
         ISS:   state_nx_s = grant_s ? FULL : RES;
         RES: begin
            if (grant_s) begin
               state_nx_s = rsp_ready ? ISS : FULL;
            end else begin
               state_nx_s = rsp_ready ? EMPTY : RES;
            end
         end
         FULL: begin
            if (rsp_ready) begin
               state_nx_s = grant_s ? FULL : RES;
            end else begin
               state_nx_s = FULL;
            end
         end
         default: state_nx_s = EMPTY;
      endcase
   end

   // Pipeline state, run flag and registered occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= EMPTY;
         run_r   <= 1'b0;
         occ_r   <= 2'd0;
      end else begin
         state_r <= state_nx_s;
         run_r   <= 1'b1;
         occ_r   <= {1'b0, state_nx_s[1]} + {1'b0, state_nx_s[0]};
      end
   end

   // Issue register, result register, round-robin pointer and completion counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r      <= {IDW{1'b0}};
         iss_x_r    <= 32'h0000_0000;
         iss_s_r    <= 5'd0;
         iss_left_r <= 1'b0;
         iss_log_r  <= 1'b0;
         iss_id_r   <= {IDW{1'b0}};
         rsp_z_r    <= 32'h0000_0000;
         rsp_id_r   <= {IDW{1'b0}};
         opcnt_r    <= {CNTW{1'b0}};
      end else begin
         if (grant_s) begin
            iss_x_r    <= sel_x_s;
            iss_s_r    <= sel_s_s;
            iss_left_r <= sel_left_s;
            iss_log_r  <= sel_log_s;
            iss_id_r   <= gnt_id_s;
            ptr_r      <= ptr_nx_s;
         end
         if (res_adv_s) begin
            rsp_z_r  <= sh_z;
            rsp_id_r <= iss_id_r;
         end
         if (res_v_s && rsp_ready) begin
            opcnt_r <= opcnt_r + CNTW'(1);
         end
      end
   end

   assign sh_x      = iss_x_r;
   assign sh_s      = iss_s_r;
   assign sh_left   = iss_left_r;
   assign sh_log    = iss_log_r;
   assign rsp_valid = res_v_s;
   assign rsp_z     = rsp_z_r;
   assign rsp_id    = rsp_id_r;
   assign occ       = occ_r;
   assign opcnt     = opcnt_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: vector table for single shifts plus hand-written
// sequences for streaming, stall, reset-in-flight and counter wrap.
module tb_shift_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NREQ-1:0]     req_valid = 4'h0;
   logic [NREQ-1:0]     req_ready;
   logic [32*NREQ-1:0]  req_x = '0;
   logic [5*NREQ-1:0]   req_s = '0;
   logic [NREQ-1:0]     req_left = '0;
   logic [NREQ-1:0]     req_log = '0;
   logic [31:0]         sh_x;
   logic [4:0]          sh_s;
   logic                sh_left;
   logic                sh_log;
   logic [31:0]         sh_z;
   logic                rsp_valid;
   logic                rsp_ready = 1'b1;
   logic [31:0]         rsp_z;
   logic [IDW-1:0]      rsp_id;
   logic [1:0]          occ;
   logic [CNTW-1:0]     opcnt;

   int checks = 0;
   int passes = 0;

   shift_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_s(req_s), .req_left(req_left), .req_log(req_log),
      .sh_x(sh_x), .sh_s(sh_s), .sh_left(sh_left), .sh_log(sh_log), .sh_z(sh_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_id(rsp_id),
      .occ(occ), .opcnt(opcnt)
   );

   always #5 clk = ~clk;

   // Reference barrel shifter standing in for the shared unit
   function automatic logic [31:0] shf(input logic [31:0] x, input logic [4:0] s,
                                       input logic l, input logic g);
      if (l) return x << s;
      else if (g) return x >> s;
      else return 32'($signed(x) >>> s);
   endfunction

   always_comb sh_z = shf(sh_x, sh_s, sh_left, sh_log);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic set_req(input int id, input logic [31:0] x, input logic [4:0] s,
                          input logic l, input logic g);
      req_x[32*id +: 32] = x;
      req_s[5*id +: 5]   = s;
      req_left[id]       = l;
      req_log[id]        = g;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      int          id;
      logic [31:0] x;
      logic [4:0]  s;
      logic        left;
      logic        lg;
      logic [31:0] z;
   } vec_t;

   vec_t vt[9];

   initial begin
      int  exp_cnt;
      logic got;
      vt[0] = '{0, 32'h8000_0001, 5'd4,  1'b0, 1'b0, 32'hF800_0000};
      vt[1] = '{2, 32'h0000_0003, 5'd31, 1'b1, 1'b0, 32'h8000_0000};
      vt[2] = '{1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'h0000_0001};
      vt[3] = '{3, 32'h1234_5678, 5'd0,  1'b1, 1'b1, 32'h1234_5678};
      vt[4] = '{0, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
      vt[5] = '{3, 32'h7F00_FF00, 5'd8,  1'b0, 1'b0, 32'h007F_00FF};
      vt[6] = '{1, 32'h0F0F_0F0F, 5'd4,  1'b1, 1'b0, 32'hF0F0_F0F0};
      vt[7] = '{2, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'hFFFF_FFFF};
      vt[8] = '{0, 32'hA5A5_0000, 5'd16, 1'b0, 1'b1, 32'h0000_A5A5};

      // Reset values, with requests pending
      for (int i = 0; i < NREQ; i++) set_req(i, 32'hFFFF_0000 + 32'(i), 5'd3, 1'b1, 1'b0);
      req_valid = 4'hF;
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_z", rsp_z, 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_sh_x", sh_x, 32'h0);
      chk("rst_occ", 32'(occ), 32'h0);
      chk("rst_opcnt", 32'(opcnt), 32'h0);
      req_valid = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Single-shot vectors, two-cycle latency
      exp_cnt = 0;
      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         set_req(vt[v].id, vt[v].x, vt[v].s, vt[v].left, vt[v].lg);
         req_valid = 4'(1 << vt[v].id);
         #1;
         chk($sformatf("v%0d_grant", v), 32'(req_ready), 32'(1 << vt[v].id));
         @(negedge clk);
         req_valid = 4'h0;
         #1;
         chk($sformatf("v%0d_early_valid", v), 32'(rsp_valid), 32'h0);
         chk($sformatf("v%0d_sh_x", v), sh_x, vt[v].x);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
         chk($sformatf("v%0d_rsp_z", v), rsp_z, vt[v].z);
         chk($sformatf("v%0d_rsp_id", v), 32'(rsp_id), 32'(vt[v].id));
         chk($sformatf("v%0d_opcnt", v), 32'(opcnt), 32'(exp_cnt));
         exp_cnt++;
      end

      // All four requesting, consumer always ready: round robin, one per cycle
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * 32'(i + 1), 5'd0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         req_valid = 4'hF;
         #1;
         chk($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(1 << (k % 4)));
         chk($sformatf("rr%0d_opcnt", k), 32'(opcnt), (k >= 2) ? 32'(k - 2) : 32'h0);
         if (k >= 2) begin
            chk($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'((k - 2) % 4));
            chk($sformatf("rr%0d_rsp_z", k), rsp_z, 32'h100 * 32'((k - 2) % 4 + 1));
         end else begin
            chk($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'h0);
         end
      end
      req_valid = 4'h0;
      repeat (3) @(negedge clk);

      // Consumer stalled with three back-to-back requests
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, 32'(i + 1), 5'd1, 1'b1, 1'b0);
      rsp_ready = 1'b0;
      @(negedge clk); req_valid = 4'b0111; #1;
      chk("st_grant0", 32'(req_ready), 32'b0001);
      @(negedge clk); req_valid = 4'b0110; #1;
      chk("st_grant1", 32'(req_ready), 32'b0010);
      chk("st_occ1", 32'(occ), 32'h1);
      @(negedge clk); req_valid = 4'b0100; #1;
      chk("st_full_ready", 32'(req_ready), 32'h0);
      chk("st_full_occ", 32'(occ), 32'h2);
      chk("st_full_id", 32'(rsp_id), 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         chk("st_hold_ready", 32'(req_ready), 32'h0);
         chk("st_hold_occ", 32'(occ), 32'h2);
         chk("st_hold_sh_x", sh_x, 32'h2);
         chk("st_hold_z", rsp_z, 32'h2);
      end
      @(negedge clk); rsp_ready = 1'b1; #1;
      chk("st_grant2", 32'(req_ready), 32'b0100);
      @(negedge clk); req_valid = 4'h0; #1;
      chk("st_rel_id1", 32'(rsp_id), 32'h1);
      chk("st_rel_z1", rsp_z, 32'h4);
      chk("st_rel_occ", 32'(occ), 32'h2);
      @(negedge clk); #1;
      chk("st_rel_id2", 32'(rsp_id), 32'h2);
      chk("st_rel_z2", rsp_z, 32'h6);
      chk("st_rel_occ1", 32'(occ), 32'h1);
      @(negedge clk); #1;
      chk("st_end_occ", 32'(occ), 32'h0);
      chk("st_end_opcnt", 32'(opcnt), 32'h3);

      // Reset asserted mid-stall; pointer would otherwise favour req2
      set_req(0, 32'h5, 5'd0, 1'b0, 1'b0);
      set_req(1, 32'h7, 5'd0, 1'b0, 1'b0);
      set_req(2, 32'h9, 5'd0, 1'b0, 1'b0);
      rsp_ready = 1'b0;
      @(negedge clk); req_valid = 4'b0011; #1;
      chk("rs_grant0", 32'(req_ready), 32'b0001);
      @(negedge clk); req_valid = 4'b0010; #1;
      chk("rs_grant1", 32'(req_ready), 32'b0010);
      @(negedge clk); req_valid = 4'b0101; #1;
      chk("rs_full_occ", 32'(occ), 32'h2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rs_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rs_occ", 32'(occ), 32'h0);
      chk("rs_opcnt", 32'(opcnt), 32'h0);
      chk("rs_ready", 32'(req_ready), 32'h0);
      chk("rs_rsp_z", rsp_z, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (req_ready != 4'h0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rs_grant_seen", 32'(got), 32'h1);
      chk("rs_first_grant", 32'(req_ready), 32'b0001);
      @(negedge clk); req_valid = 4'h0;
      @(negedge clk); #1;
      chk("rs_rsp_id", 32'(rsp_id), 32'h0);
      chk("rs_rsp_z5", rsp_z, 32'h5);
      repeat (2) @(negedge clk);

      // Counter wrap
      do_reset();
      req_valid = 4'hF;
      got = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         if (opcnt == 8'hFF) begin
            got = 1'b1;
            break;
         end
      end
      chk("wr_reached_max", 32'(got), 32'h1);
      chk("wr_streaming", 32'(rsp_valid), 32'h1);
      req_valid = 4'h0;
      @(negedge clk); #1;
      chk("wr_wrap", 32'(opcnt), 32'h0);
      @(negedge clk); #1;
      chk("wr_after", 32'(opcnt), 32'h1);
      @(negedge clk); #1;
      chk("wr_idle_cnt", 32'(opcnt), 32'h1);
      chk("wr_idle_occ", 32'(occ), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
